// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared width helper and default word type for the sigma-delta ADC path
package sigma_delta_pkg;

  localparam int ADC_BITLEN_DEFAULT = 18;

  typedef logic signed [ADC_BITLEN_DEFAULT-1:0] cic_word_t;

  // Bits a CIC needs to hold R^N without overflow: N*log2(R) plus sign and headroom.
  function automatic int cic_width(input int n, input int r);
    return 2 + n * $clog2(r);
  endfunction

endpackage

// File: rtl/sigma_delta_adc.sv
// rtl/sigma_delta_adc.sv - CIC decimator, offset removal and optional DC blocker on the 1-bit modulator stream
// Optional blocker: SIGMA_DELTA_DC_BLOCK_EN
module sigma_delta_adc
  import sigma_delta_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int CIC_STAGES      = 2,
  parameter int ADC_BITLEN      = 18,
  parameter int SIGNED_OUTPUT   = 1,
  parameter int DC_BLOCK_SHIFT  = 7
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_fb,
  output logic signed [ADC_BITLEN-1:0] o_y,
  output logic                         o_valid
);

  typedef logic signed [ADC_BITLEN-1:0] word_t;

  localparam int CNT_W  = $clog2(OVERSAMPLE_RATE);
  localparam int G_LOG2 = cic_width(CIC_STAGES, OVERSAMPLE_RATE) - 2;
  localparam word_t ONE    = {{(ADC_BITLEN-1){1'b0}}, 1'b1};
  localparam word_t OFFSET = (SIGNED_OUTPUT != 0) ? (ONE << (G_LOG2 - 1)) : '0;

  word_t            r_int [CIC_STAGES];
  word_t            r_dly [CIC_STAGES];
  word_t            r_cic;
  logic             r_dec_valid;
  logic [CNT_W-1:0] r_cnt;
  word_t            r_y;
  logic             r_valid;

  logic  w_dec;
  word_t w_comb [CIC_STAGES+1];
  word_t w_code;
  word_t w_y_next;

  assign w_dec = (r_cnt == CNT_W'(OVERSAMPLE_RATE - 1));

  always_comb begin
    w_comb[0] = r_int[CIC_STAGES-1];
    for (int i = 0; i < CIC_STAGES; i++) begin
      w_comb[i+1] = w_comb[i] - r_dly[i];
    end
  end

  // Integrators wrap freely; the combs undo the wrap as long as ADC_BITLEN covers R^N.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CIC_STAGES; i++) begin
        r_int[i] <= '0;
        r_dly[i] <= '0;
      end
      r_cnt       <= '0;
      r_cic       <= '0;
      r_dec_valid <= 1'b0;
    end else begin
      r_int[0] <= r_int[0] + word_t'(i_fb);
      for (int i = 1; i < CIC_STAGES; i++) begin
        r_int[i] <= r_int[i] + r_int[i-1];
      end
      r_cnt       <= r_cnt + 1'b1;
      r_dec_valid <= w_dec;
      if (w_dec) begin
        for (int i = 0; i < CIC_STAGES; i++) begin
          r_dly[i] <= w_comb[i];
        end
        r_cic <= w_comb[CIC_STAGES];
      end
    end
  end

  assign w_code = r_cic - OFFSET;

`ifdef SIGMA_DELTA_DC_BLOCK_EN
  word_t r_avg;
  word_t w_avg_next;

  assign w_avg_next = r_avg + ((w_code - r_avg) >>> DC_BLOCK_SHIFT);
  assign w_y_next   = w_code - w_avg_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_avg <= '0;
    end else if (r_dec_valid) begin
      r_avg <= w_avg_next;
    end
  end
`else
  logic w_unused_dc_shift;
  assign w_unused_dc_shift = (DC_BLOCK_SHIFT != 0);
  assign w_y_next          = w_code;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_dec_valid;
      if (r_dec_valid) begin
        r_y <= w_y_next;
      end
    end
  end

  assign o_y     = r_y;
  assign o_valid = r_valid;

endmodule

// File: rtl/sigma_delta_adc_harness.sv
// rtl/sigma_delta_adc_harness.sv - behavioural RC/comparator front-end around the digital decimation path
// Optional DC blocker in the digital path: SIGMA_DELTA_DC_BLOCK_EN
module sigma_delta_adc_harness
  import sigma_delta_pkg::*;
#(
  parameter real VCC             = 2.5,
  parameter int  CAP_FUDGE       = 128,
  parameter int  OVERSAMPLE_RATE = 256,
  parameter int  CIC_STAGES      = 2,
  parameter int  ADC_BITLEN      = $bits(cic_word_t),
  parameter int  SIGNED_OUTPUT   = 1,
  parameter int  DC_BLOCK_SHIFT  = 7
) (
  input  logic clk,
  input  logic rst,
  input  real  adc_input,
  output real  adc_output,
  output logic adc_valid
);

  localparam int  G_LOG2     = cic_width(CIC_STAGES, OVERSAMPLE_RATE) - 2;
  localparam real FULL_SCALE = 2.0 ** G_LOG2;

  real                         r_v_cap;
  logic                        r_fb;
  logic signed [ADC_BITLEN-1:0] w_y;
  logic                        w_valid;

  // Feedback pin charges the cap toward VCC or 0; comparator is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_cap <= VCC / 2.0;
      r_fb    <= 1'b0;
    end else begin
      r_v_cap <= r_v_cap + ((r_fb ? VCC : 0.0) - r_v_cap) / $itor(CAP_FUDGE);
      r_fb    <= (adc_input > r_v_cap);
    end
  end

  sigma_delta_adc #(
    .OVERSAMPLE_RATE (OVERSAMPLE_RATE),
    .CIC_STAGES      (CIC_STAGES),
    .ADC_BITLEN      (ADC_BITLEN),
    .SIGNED_OUTPUT   (SIGNED_OUTPUT),
    .DC_BLOCK_SHIFT  (DC_BLOCK_SHIFT)
  ) u_adc (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_fb    (r_fb),
    .o_y     (w_y),
    .o_valid (w_valid)
  );

  assign adc_output = $itor(w_y) * VCC / FULL_SCALE;
  assign adc_valid  = w_valid;

endmodule

// File: tb/tb_sigma_delta_adc_harness.sv
// tb/tb_sigma_delta_adc_harness.sv - directed self-checking bench for sigma_delta_adc_harness
module tb_sigma_delta_adc_harness;

  localparam int  R     = 256;
  localparam int  LIMIT = 2 * R + 16;
  localparam real PI    = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  adc_input = 1.25;
  real  adc_output;
  logic adc_valid;

  int n_checks = 0;
  int n_errors = 0;

  sigma_delta_adc_harness dut (
    .clk        (clk),
    .rst        (rst),
    .adc_input  (adc_input),
    .adc_output (adc_output),
    .adc_valid  (adc_valid)
  );

  always #5 clk = ~clk;

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic wait_strobe(output int gap, output bit timed_out);
    bit hit;
    hit = 1'b0;
    gap = 0;
    while (!hit && gap < LIMIT) begin
      @(posedge clk); #1;
      gap++;
      if (adc_valid) hit = 1'b1;
    end
    timed_out = !hit;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adc_input = 1.25;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (adc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid: got %b expected 0", adc_valid);
    end
    n_checks++;
    if (adc_output != 0.0) begin
      n_errors++;
      $display("FAIL reset_output: got %f expected 0.0", adc_output);
    end
  endtask

  task automatic test_first_strobe();
    int gap;
    bit to;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_strobe(gap, to);
    n_checks++;
    if (to || gap != R + 1) begin
      n_errors++;
      $display("FAIL first_strobe_latency: got %0d (timeout=%0d) expected %0d", gap, to, R + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (adc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL first_strobe_width: got %b expected 0", adc_valid);
    end
  endtask

  task automatic test_dc_mid();
    int gap;
    bit to;
    adc_input = 1.25;
    for (int s = 0; s < 40; s++) begin
      wait_strobe(gap, to);
      if (s >= 4) begin
        n_checks++;
        if (to || absr(adc_output) >= 0.02) begin
          n_errors++;
          $display("FAIL dc_mid_sample%0d: got %f (timeout=%0d) expected |v|<0.02", s, adc_output, to);
        end
      end
    end
  endtask

  task automatic test_step_1875();
    int gap;
    bit to;
    adc_input = 1.875;
    for (int s = 0; s < 26; s++) begin
      wait_strobe(gap, to);
      if (s >= 6) begin
        n_checks++;
        if (to || absr(adc_output - 0.625) >= 0.02) begin
          n_errors++;
          $display("FAIL step_1875_sample%0d: got %f (timeout=%0d) expected 0.625+-0.02", s, adc_output, to);
        end
      end
    end
  endtask

  task automatic test_cosine();
    real vmax, vmin;
    int  nsamp;
    vmax  = -10.0;
    vmin  = 10.0;
    nsamp = 0;
    for (int n = 0; n < 130 * R; n++) begin
      adc_input = 1.25 + 1.2375 * $cos(2.0 * PI * 440.0 * $itor(n) / 11468800.0);
      @(posedge clk); #1;
      if (adc_valid) begin
        nsamp++;
        if (nsamp > 8) begin
          if (adc_output > vmax) vmax = adc_output;
          if (adc_output < vmin) vmin = adc_output;
        end
      end
    end
    n_checks++;
    if (nsamp != 130) begin
      n_errors++;
      $display("FAIL cosine_sample_count: got %0d expected 130", nsamp);
    end
    n_checks++;
    if (absr(vmax - 1.2375) > 0.037) begin
      n_errors++;
      $display("FAIL cosine_peak: got %f expected 1.2375+-3%%", vmax);
    end
    n_checks++;
    if (absr(vmin + 1.2375) > 0.037) begin
      n_errors++;
      $display("FAIL cosine_trough: got %f expected -1.2375+-3%%", vmin);
    end
    adc_input = 1.875;
  endtask

`ifdef SIGMA_DELTA_DC_BLOCK_EN
  task automatic test_dc_blocker();
    int gap;
    bit to;
    adc_input = 1.875;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      wait_strobe(gap, to);
      if (s == 3) begin
        n_checks++;
        if (to || absr(adc_output - 0.625) >= 0.03) begin
          n_errors++;
          $display("FAIL blocker_first_settled: got %f (timeout=%0d) expected 0.625+-0.03", adc_output, to);
        end
      end
    end
    n_checks++;
    if (adc_output >= 0.1 || adc_output <= 0.0) begin
      n_errors++;
      $display("FAIL blocker_decay_300: got %f expected 0<v<0.1", adc_output);
    end
  endtask
`endif

  task automatic test_strobe_spacing();
    int  gap;
    bit  to;
    bit  held;
    real prev;
    wait_strobe(gap, to);
    prev = adc_output;
    held = 1'b1;
    for (int s = 0; s < 50; s++) begin
      gap = 0;
      to  = 1'b1;
      while (to && gap < LIMIT) begin
        @(posedge clk); #1;
        gap++;
        if (adc_valid) to = 1'b0;
        else if (adc_output != prev) held = 1'b0;
      end
      prev = adc_output;
      n_checks++;
      if (to || gap != R) begin
        n_errors++;
        $display("FAIL strobe_spacing%0d: got %0d (timeout=%0d) expected %0d", s, gap, to, R);
      end
    end
    n_checks++;
    if (!held) begin
      n_errors++;
      $display("FAIL output_hold: got change between strobes expected hold");
    end
  endtask

  task automatic test_reset_mid();
    int gap;
    bit to;
    adc_input = 1.875;
    wait_strobe(gap, to);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (adc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_valid: got %b expected 0", adc_valid);
    end
    n_checks++;
    if (adc_output != 0.0) begin
      n_errors++;
      $display("FAIL mid_reset_output: got %f expected 0.0", adc_output);
    end
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_strobe(gap, to);
    n_checks++;
    if (to || gap != R + 1) begin
      n_errors++;
      $display("FAIL mid_reset_restart: got %0d (timeout=%0d) expected %0d", gap, to, R + 1);
    end
  endtask

  task automatic test_reset_on_strobe();
    int gap;
    bit to;
    repeat (R - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (adc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL strobe_reset_valid: got %b expected 0", adc_valid);
    end
    n_checks++;
    if (adc_output != 0.0) begin
      n_errors++;
      $display("FAIL strobe_reset_output: got %f expected 0.0", adc_output);
    end
    rst = 1'b0;
    wait_strobe(gap, to);
    n_checks++;
    if (to || gap != R + 1) begin
      n_errors++;
      $display("FAIL strobe_reset_restart: got %0d (timeout=%0d) expected %0d", gap, to, R + 1);
    end
  endtask

  initial begin
    test_reset();
    test_first_strobe();
`ifdef SIGMA_DELTA_DC_BLOCK_EN
    test_dc_blocker();
`else
    test_dc_mid();
    test_step_1875();
    test_cosine();
`endif
    test_strobe_spacing();
    test_reset_mid();
    test_reset_on_strobe();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
